// File: rtl/ifid_pkg.sv
// rtl/ifid_pkg.sv - shared entry type, bubble encoding and field positions for the IF/ID queue
package ifid_pkg;

  localparam int IFID_XLEN = 32;

  typedef struct packed {
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] instr;
  } fetch_entry_t;

  localparam logic [IFID_XLEN-1:0] NOP_INSTR = '0;

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int F7_LSB  = 25;
  localparam int CSR_LSB = 20;

endpackage

// File: rtl/ifid_field_decode.sv
// rtl/ifid_field_decode.sv - slices the head instruction into register/opcode/CSR/immediate fields
module ifid_field_decode
  import ifid_pkg::*;
#(
  parameter int XLEN = IFID_XLEN
) (
  input  logic [XLEN-1:0] instr,
  output logic [4:0]      read_reg1,
  output logic [4:0]      read_reg2,
  output logic [4:0]      write_addr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] immediate
);

  assign read_reg1  = instr[RS1_LSB +: 5];
  assign read_reg2  = instr[RS2_LSB +: 5];
  assign write_addr = instr[RD_LSB +: 5];
  assign opcode     = instr[6:0];
  assign funct3     = instr[F3_LSB +: 3];
  assign funct7     = instr[F7_LSB +: 7];
  assign csr_addr   = instr[CSR_LSB +: 12];
  // Immediate extraction is left to ID, which knows the instruction format.
  assign immediate  = instr;

endmodule

// File: rtl/ifid_fetch_queue.sv
// rtl/ifid_fetch_queue.sv - DEPTH-entry IF/ID decoupling FIFO; IFID_BYPASS_EN adds empty-queue fall-through
module ifid_fetch_queue
  import ifid_pkg::*;
#(
  parameter int XLEN  = IFID_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       CSR_reset,
  input  logic                       flush,
  input  logic                       if_valid,
  input  logic [XLEN-1:0]            if_pc,
  input  logic [XLEN-1:0]            if_instr,
  output logic                       if_ready,
  input  logic                       id_ready,
  input  logic                       dm_stall,
  input  logic                       CSR_stall,
  output logic                       id_valid,
  output logic [XLEN-1:0]            ID_pc_out,
  output logic [XLEN-1:0]            id_instr,
  output logic [4:0]                 read_reg1,
  output logic [4:0]                 read_reg2,
  output logic [4:0]                 write_addr,
  output logic [6:0]                 opcode,
  output logic [2:0]                 funct3,
  output logic [6:0]                 funct7,
  output logic [11:0]                csr_addr,
  output logic [XLEN-1:0]            immediate,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          nonempty, bypass, enq, deq, push, pop;

  assign nonempty = (occ_q != '0);

`ifdef IFID_BYPASS_EN
  assign bypass = ~nonempty & if_valid & ~flush & ~CSR_stall;
`else
  assign bypass = 1'b0;
`endif

  assign if_ready = (occ_q != FULL) & ~CSR_stall & ~flush;
  assign id_valid = nonempty | bypass;
  assign enq      = if_valid & if_ready;
  assign deq      = id_valid & id_ready & ~dm_stall & ~CSR_stall;
  // A bypassed entry consumed in the same cycle never touches storage.
  assign push     = enq & ~(bypass & deq);
  assign pop      = deq & nonempty;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    ID_pc_out = '0;
    id_instr  = NOP_INSTR;
    if (nonempty) begin
      ID_pc_out = head.pc;
      id_instr  = head.instr;
    end else if (bypass) begin
      ID_pc_out = if_pc;
      id_instr  = if_instr;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (CSR_reset || flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is deliberately unreset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !CSR_reset) mem_q[wr_ptr_q] <= '{pc: if_pc, instr: if_instr};
  end

  assign occupancy = occ_q;

  ifid_field_decode #(.XLEN(XLEN)) u_decode (
    .instr      (id_instr),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_addr (write_addr),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7     (funct7),
    .csr_addr   (csr_addr),
    .immediate  (immediate)
  );

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// tb/tb_ifid_fetch_queue.sv - self-checking bench for ifid_fetch_queue against a queue-based model
module tb_ifid_fetch_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int OW    = $clog2(DEPTH+1);
`ifdef IFID_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            CSR_reset = 1'b0;
  logic            flush = 1'b0;
  logic            if_valid = 1'b0;
  logic [XLEN-1:0] if_pc = '0;
  logic [XLEN-1:0] if_instr = '0;
  logic            id_ready = 1'b0;
  logic            dm_stall = 1'b0;
  logic            CSR_stall = 1'b0;
  logic            if_ready, id_valid;
  logic [XLEN-1:0] ID_pc_out, id_instr, immediate;
  logic [4:0]      read_reg1, read_reg2, write_addr;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [11:0]     csr_addr;
  logic [OW-1:0]   occupancy;

  int cmp_count  = 0;
  int fail_count = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;
  pair_t model_q[$];

  always #5 clk = ~clk;

  ifid_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .CSR_reset(CSR_reset), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .id_ready(id_ready), .dm_stall(dm_stall), .CSR_stall(CSR_stall),
    .id_valid(id_valid), .ID_pc_out(ID_pc_out), .id_instr(id_instr),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_addr(write_addr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .csr_addr(csr_addr),
    .immediate(immediate), .occupancy(occupancy)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h00500093 ^ (pc << 12);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain queue of {pc, instr}, updated on each clock edge from the handshake rules.
  int   m_size;
  logic m_rdy, m_byp, m_pop;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
    end else if (CSR_reset || flush) begin
      model_q.delete();
    end else begin
      m_size = model_q.size();
      m_rdy  = (m_size < DEPTH) && !CSR_stall;
      m_byp  = BYPASS && (m_size == 0) && if_valid && !CSR_stall;
      m_pop  = ((m_size > 0) || m_byp) && id_ready && !dm_stall && !CSR_stall;
      if (m_pop && m_size > 0) void'(model_q.pop_front());
      if (if_valid && m_rdy && !(m_byp && m_pop)) model_q.push_back('{pc: if_pc, instr: if_instr});
    end
  end

  int          e_size;
  logic        e_byp, e_valid;
  logic [31:0] e_pc, e_instr;
  always @(negedge clk) begin
    if (reset) begin
      e_size  = model_q.size();
      e_byp   = BYPASS && (e_size == 0) && if_valid && !flush && !CSR_stall;
      e_valid = (e_size > 0) || e_byp;
      e_pc    = 32'h0;
      e_instr = 32'h0;
      if (e_size > 0) begin
        e_pc    = model_q[0].pc;
        e_instr = model_q[0].instr;
      end else if (e_byp) begin
        e_pc    = if_pc;
        e_instr = if_instr;
      end
      chk("m_if_ready", 64'(if_ready), 64'((e_size < DEPTH) && !CSR_stall && !flush));
      chk("m_id_valid", 64'(id_valid), 64'(e_valid));
      chk("m_occupancy", 64'(occupancy), 64'(e_size));
      chk("m_pc", 64'(ID_pc_out), 64'(e_pc));
      chk("m_instr", 64'(id_instr), 64'(e_instr));
      chk("m_rs1", 64'(read_reg1), 64'(e_instr[19:15]));
      chk("m_rs2", 64'(read_reg2), 64'(e_instr[24:20]));
      chk("m_rd", 64'(write_addr), 64'(e_instr[11:7]));
      chk("m_opcode", 64'(opcode), 64'(e_instr[6:0]));
      chk("m_funct3", 64'(funct3), 64'(e_instr[14:12]));
      chk("m_funct7", 64'(funct7), 64'(e_instr[31:25]));
      chk("m_csr", 64'(csr_addr), 64'(e_instr[31:20]));
      chk("m_imm", 64'(immediate), 64'(e_instr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_instr = instr_of(pc);
  endtask

  logic [31:0] drain_pcs [4];

  initial begin
    drain_pcs = '{32'h0, 32'h4, 32'h8, 32'hC};
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);

    // Reset mid-traffic
    drive(1'b1, 32'h40); cyc();
    drive(1'b1, 32'h44); cyc();
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    reset = 1'b0;
    #1;
    chk("arst_id_valid", 64'(id_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_instr", 64'(id_instr), 64'd0);
    chk("arst_if_ready", 64'(if_ready), 64'd1);
    drive(1'b0, 32'h0);
    cyc();
    reset = 1'b1;

    // Fill to DEPTH; fifth push must be refused
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, drain_pcs[i]);
      cyc();
    end
    drive(1'b1, 32'h10);
    #1;
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_if_ready", 64'(if_ready), 64'd0);
    cyc();
    chk("full_occ_after5", 64'(occupancy), 64'd4);
    chk("head_pc", 64'(ID_pc_out), 64'h0);
    chk("head_instr", 64'(id_instr), 64'h00500093);
    chk("head_rs1", 64'(read_reg1), 64'd0);
    chk("head_rd", 64'(write_addr), 64'd1);
    chk("head_opcode", 64'(opcode), 64'h13);

    // Drain in order
    drive(1'b0, 32'h0);
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pc", 64'(ID_pc_out), 64'(drain_pcs[i]));
      cyc();
    end
    chk("drained_valid", 64'(id_valid), 64'd0);
    chk("drained_instr", 64'(id_instr), 64'd0);
    chk("drained_occ", 64'(occupancy), 64'd0);

    // Flush beats a same-cycle enqueue
    id_ready = 1'b0;
    drive(1'b1, 32'h100); cyc();
    drive(1'b1, 32'h104); cyc();
    drive(1'b1, 32'h108); cyc();
    chk("pre_flush_occ", 64'(occupancy), 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'h10C);
    #1;
    chk("flush_if_ready", 64'(if_ready), 64'd0);
    cyc();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(id_valid), 64'd0);
    cyc();
    chk("flush_not_stored", 64'(occupancy), 64'd0);

    // Synchronous CSR_reset
    drive(1'b1, 32'h180); cyc();
    drive(1'b0, 32'h0);
    CSR_reset = 1'b1;
    cyc();
    CSR_reset = 1'b0;
    #1;
    chk("csr_reset_occ", 64'(occupancy), 64'd0);

    // Stalls
    drive(1'b1, 32'h300); cyc();
    drive(1'b1, 32'h304); cyc();
    dm_stall = 1'b1;
    id_ready = 1'b1;
    drive(1'b1, 32'h308);
    cyc();
    chk("dm_stall_occ", 64'(occupancy), 64'd3);
    chk("dm_stall_head", 64'(ID_pc_out), 64'h300);
    drive(1'b0, 32'h0);
    dm_stall  = 1'b0;
    CSR_stall = 1'b1;
    drive(1'b1, 32'h30C);
    #1;
    chk("csr_stall_if_ready", 64'(if_ready), 64'd0);
    cyc();
    chk("csr_stall_occ", 64'(occupancy), 64'd3);
    chk("csr_stall_head", 64'(ID_pc_out), 64'h300);
    CSR_stall = 1'b0;
    drive(1'b0, 32'h0);
    cyc();
    chk("unstall_occ", 64'(occupancy), 64'd2);
    chk("unstall_head", 64'(ID_pc_out), 64'h304);
    cyc(); cyc();
    chk("stall_drained", 64'(occupancy), 64'd0);

    // Pointer wrap under simultaneous enqueue/dequeue
    id_ready = 1'b0;
    drive(1'b1, 32'h200); cyc();
    drive(1'b1, 32'h204); cyc();
    id_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h208 + 32'(4 * k));
      #1;
      chk("wrap_head", 64'(ID_pc_out), 64'(32'h200 + 32'(4 * k)));
      chk("wrap_occ", 64'(occupancy), 64'd2);
      cyc();
    end
    drive(1'b0, 32'h0);
    cyc(); cyc();
    chk("wrap_drained", 64'(occupancy), 64'd0);

    // Empty-queue latency
    drive(1'b1, 32'h400);
    #1;
`ifdef IFID_BYPASS_EN
    chk("byp_valid", 64'(id_valid), 64'd1);
    chk("byp_pc", 64'(ID_pc_out), 64'h400);
    cyc();
    drive(1'b0, 32'h0);
    #1;
    chk("byp_occ", 64'(occupancy), 64'd0);
`else
    chk("lat_valid0", 64'(id_valid), 64'd0);
    chk("lat_pc0", 64'(ID_pc_out), 64'h0);
    cyc();
    drive(1'b0, 32'h0);
    #1;
    chk("lat_valid1", 64'(id_valid), 64'd1);
    chk("lat_pc1", 64'(ID_pc_out), 64'h400);
    chk("lat_occ1", 64'(occupancy), 64'd1);
    cyc();
    chk("lat_occ_end", 64'(occupancy), 64'd0);
`endif

    // Patterned mixed traffic, checked by the model every cycle
    for (int i = 0; i < 40; i++) begin
      drive((i % 3) != 0, 32'h800 + 32'(4 * i));
      id_ready  = (i % 4) != 1;
      dm_stall  = (i % 7) == 3;
      CSR_stall = (i % 11) == 5;
      flush     = (i == 27);
      cyc();
    end
    drive(1'b0, 32'h0);
    id_ready  = 1'b1;
    dm_stall  = 1'b0;
    CSR_stall = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("final_occ", 64'(occupancy), 64'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
